// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the 5-stage core.
// Prioritises fault, trap and masked IRQ sources, holds the return address (iar)
// and switches user/supervisor mode. It redirects fetch to a per-cause vector on
// entry, and back to iar on rfe.
// Ports:
//   clk, reset (async, active-low)
//   irq_in/irq_mask     level IRQ requests and per-line enables
//   mem_fault, illegal, trap, ex_memwrite, rfe, pc_8   status of the EX instruction
//   exc_taken, redirect 1-cycle pulses (flush / load PC)
//   redirect_pc         fetch target while redirect=1
//   iar, cause, s_u     saved return address, latched cause, 1 = user mode
//   halted              double fault, held until reset
module exc_ctrl #(
   parameter int unsigned NUM_IRQ     = 4,
   parameter logic [31:0] VECTOR_BASE = 32'h0000_0100,
   parameter int unsigned VEC_STRIDE  = 8,
   parameter logic [31:0] RESET_PC    = 32'h0001_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               mem_fault,
   input  logic               illegal,
   input  logic               trap,
   input  logic               ex_memwrite,
   input  logic               rfe,
   input  logic [31:0]        pc_8,
   output logic               exc_taken,
   output logic               redirect,
   output logic [31:0]        redirect_pc,
   output logic [31:0]        iar,
   output logic [3:0]         cause,
   output logic               s_u,
   output logic               halted
);

   localparam int unsigned PC_W    = 32;
   localparam int unsigned CAUSE_W = 4;

   typedef enum logic [2:0] {
      ST_USER,
      ST_ENTRY,
      ST_SUPER,
      ST_RETURN,
      ST_HALT
   } state_t;

   state_t               state;
   logic [NUM_IRQ-1:0]   irq_pend;
   logic                 irq_hit;
   logic [CAUSE_W-1:0]   irq_cause;
   logic                 evt_any;
   logic [CAUSE_W-1:0]   evt_cause;
   logic [PC_W-1:0]      evt_iar;
   logic                 sup_fault;

   // Lowest-numbered enabled IRQ line wins.
   always_comb begin
      irq_pend  = irq_in & irq_mask;
      irq_hit   = 1'b0;
      irq_cause = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (irq_pend[i]) begin
            irq_hit   = 1'b1;
            irq_cause = CAUSE_W'(8 + i);
         end
      end
   end

   // User-mode event priority and the matching return address.
   // A fault restarts the faulting instruction. A trap resumes after it.
   // An IRQ lets a store in EX complete; any other instruction restarts.
   always_comb begin
      evt_any   = 1'b1;
      evt_cause = '0;
      evt_iar   = pc_8 - PC_W'(8);
      if (mem_fault) begin
         evt_cause = CAUSE_W'(1);
      end else if (illegal || rfe) begin
         evt_cause = CAUSE_W'(2);
      end else if (trap) begin
         evt_cause = CAUSE_W'(3);
         evt_iar   = pc_8 - PC_W'(4);
      end else if (irq_hit) begin
         evt_cause = irq_cause;
         evt_iar   = ex_memwrite ? (pc_8 - PC_W'(4)) : (pc_8 - PC_W'(8));
      end else begin
         evt_any   = 1'b0;
      end
   end

   // Any synchronous event in supervisor mode is a double fault.
   assign sup_fault = mem_fault | illegal | trap;

   // Sequencer state and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_SUPER;
         exc_taken   <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= VECTOR_BASE;
         iar         <= RESET_PC;
         cause       <= '0;
         s_u         <= 1'b0;
         halted      <= 1'b0;
      end else begin
         exc_taken <= 1'b0;
         redirect  <= 1'b0;
         case (state)
            ST_USER: begin
               if (evt_any) begin
                  state       <= ST_ENTRY;
                  cause       <= evt_cause;
                  iar         <= evt_iar;
                  s_u         <= 1'b0;
                  exc_taken   <= 1'b1;
                  redirect    <= 1'b1;
                  redirect_pc <= VECTOR_BASE + PC_W'(evt_cause) * PC_W'(VEC_STRIDE);
               end
            end
            ST_ENTRY: begin
               state <= ST_SUPER;
            end
            ST_SUPER: begin
               if (sup_fault) begin
                  state  <= ST_HALT;
                  cause  <= CAUSE_W'(4'hF);
                  halted <= 1'b1;
                  s_u    <= 1'b0;
               end else if (rfe) begin
                  state       <= ST_RETURN;
                  redirect    <= 1'b1;
                  redirect_pc <= iar;
               end
            end
            ST_RETURN: begin
               state <= ST_USER;
               s_u   <= 1'b1;
            end
            ST_HALT: begin
               halted <= 1'b1;
               s_u    <= 1'b0;
            end
            default: begin
               state <= ST_HALT;
               halted <= 1'b1;
               s_u    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl.
// Every expected redirect is queued when its stimulus is driven. The monitor pops
// the queue and compares each time the DUT raises redirect.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_in;
   logic [3:0]  irq_mask;
   logic        mem_fault;
   logic        illegal;
   logic        trap;
   logic        ex_memwrite;
   logic        rfe;
   logic [31:0] pc_8;
   logic        exc_taken;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] iar;
   logic [3:0]  cause;
   logic        s_u;
   logic        halted;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] iar;
      logic [3:0]  cause;
      logic        taken;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic prev_redirect = 1'b0;

   exc_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .irq_mask    (irq_mask),
      .mem_fault   (mem_fault),
      .illegal     (illegal),
      .trap        (trap),
      .ex_memwrite (ex_memwrite),
      .rfe         (rfe),
      .pc_8        (pc_8),
      .exc_taken   (exc_taken),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .iar         (iar),
      .cause       (cause),
      .s_u         (s_u),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] vec(input logic [3:0] c);
      return 32'h0000_0100 + 32'(c) * 32'd8;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_pulses();
      mem_fault = 1'b0;
      illegal   = 1'b0;
      trap      = 1'b0;
      rfe       = 1'b0;
   endtask

   // Caller has already driven the event inputs for this USER cycle.
   task automatic entry(input logic [31:0] e_iar, input logic [3:0] e_cause);
      q.push_back('{pc: vec(e_cause), iar: e_iar, cause: e_cause, taken: 1'b1});
      tick();
      clr_pulses();
      chk("entry_su", 32'(s_u), 32'd0);
      chk("entry_cause", 32'(cause), 32'(e_cause));
      chk("entry_iar", iar, e_iar);
      tick();
      chk("super_taken_low", 32'(exc_taken), 32'd0);
      chk("super_redir_low", 32'(redirect), 32'd0);
   endtask

   // Issues rfe from SUPER and ends in the first USER cycle.
   task automatic do_rfe(input logic [31:0] e_ret, input logic [3:0] e_cause);
      rfe = 1'b1;
      q.push_back('{pc: e_ret, iar: e_ret, cause: e_cause, taken: 1'b0});
      tick();
      rfe = 1'b0;
      chk("return_su", 32'(s_u), 32'd0);
      tick();
      chk("user_su", 32'(s_u), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_su"}, 32'(s_u), 32'd0);
      chk({tag, "_iar"}, iar, 32'h0001_0000);
      chk({tag, "_cause"}, 32'(cause), 32'd0);
      chk({tag, "_taken"}, 32'(exc_taken), 32'd0);
      chk({tag, "_redir"}, 32'(redirect), 32'd0);
      chk({tag, "_rpc"}, redirect_pc, 32'h0000_0100);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (redirect) begin
         chk("redir_back_to_back", 32'(prev_redirect), 32'd0);
         if (q.size() == 0) begin
            chk("unexpected_redirect", 32'(redirect), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_redirect_pc", redirect_pc, e.pc);
            chk("sb_exc_taken", 32'(exc_taken), 32'(e.taken));
            chk("sb_iar", iar, e.iar);
            chk("sb_cause", 32'(cause), 32'(e.cause));
         end
      end
      prev_redirect <= redirect;
   end

   initial begin
      reset = 1'b0;
      irq_in = '0; irq_mask = '0; ex_memwrite = 1'b0; pc_8 = '0;
      clr_pulses();
      tick(); tick();
      chk_reset_vals("rst");
      reset = 1'b1;
      tick();
      chk("super_idle_su", 32'(s_u), 32'd0);

      // Boot: the first rfe lands at RESET_PC.
      do_rfe(32'h0001_0000, 4'd0);

      // Trap resumes after the trap instruction.
      pc_8 = 32'h0001_0010; trap = 1'b1;
      entry(32'h0001_000C, 4'd3);
      do_rfe(32'h0001_000C, 4'd3);

      // IRQ with a store in EX, then with a non-store in EX.
      irq_in = 4'b0010; irq_mask = 4'b0010; ex_memwrite = 1'b1; pc_8 = 32'h0001_0020;
      entry(32'h0001_001C, 4'd9);
      tick();
      chk("super_ignores_irq", 32'(s_u), 32'd0);
      irq_in = '0;
      do_rfe(32'h0001_001C, 4'd9);
      irq_in = 4'b0010; ex_memwrite = 1'b0;
      entry(32'h0001_0018, 4'd9);
      irq_in = '0;
      do_rfe(32'h0001_0018, 4'd9);

      // A masked line never produces an event.
      irq_in = 4'b0100; irq_mask = 4'b0010;
      tick(); tick(); tick();
      chk("masked_stay_user", 32'(s_u), 32'd1);
      irq_in = '0;

      // Every source at once: mem_fault wins. irq[0] stays high through rfe.
      pc_8 = 32'h0001_0040; mem_fault = 1'b1; trap = 1'b1;
      irq_in = 4'b0001; irq_mask = 4'b0001;
      entry(32'h0001_0038, 4'd1);
      do_rfe(32'h0001_0038, 4'd1);
      entry(32'h0001_0038, 4'd8);
      irq_in = '0;
      do_rfe(32'h0001_0038, 4'd8);

      // rfe executed in user mode is illegal.
      pc_8 = 32'h0001_0050; rfe = 1'b1;
      entry(32'h0001_0048, 4'd2);
      do_rfe(32'h0001_0048, 4'd2);

      // Double fault: illegal together with rfe in SUPER halts with no redirect.
      pc_8 = 32'h0001_0060; trap = 1'b1;
      entry(32'h0001_005C, 4'd3);
      illegal = 1'b1; rfe = 1'b1;
      tick();
      clr_pulses();
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_cause", 32'(cause), 32'hF);
      chk("halt_iar", iar, 32'h0001_005C);
      chk("halt_su", 32'(s_u), 32'd0);
      rfe = 1'b1; trap = 1'b1;
      tick(); tick(); tick();
      clr_pulses();
      chk("halt_held", 32'(halted), 32'd1);
      reset = 1'b0;
      #1;
      chk_reset_vals("rst_from_halt");
      reset = 1'b1;
      tick();
      do_rfe(32'h0001_0000, 4'd0);

      // Reset in ENTRY aborts the redirect pulse immediately.
      pc_8 = 32'h0001_0070; trap = 1'b1;
      tick();
      clr_pulses();
      reset = 1'b0;
      #1;
      chk_reset_vals("rst_in_entry");
      tick();
      reset = 1'b1;
      tick();
      do_rfe(32'h0001_0000, 4'd0);

      tick(); tick();
      chk("sb_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
